// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a framed byte stream (16-bit LE word count,
// then LE 32-bit words), writes it into instruction memory from address 0 and
// holds the core in reset until the image is complete.
//
// Parameters: ADDR_W (imem address width), TIMEOUT (idle cycles between bytes).
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   start_i               request a new load (level)
//   byte_valid_i, byte_i  incoming byte stream
//   byte_ready_o          loader accepts a byte this cycle
//   imem_we_o/addr_o/wdata_o  instruction memory write port
//   core_rst_o            reset to the core (held while loading / on error)
//   busy_o, err_o         load in progress / last load failed
//   words_loaded_o        words written by the last/current load
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMR_ONE  = TW'(1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_RUN,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        len_lo_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       shreg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [TW-1:0]     timer_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic            xfer;
    logic            load_start;
    logic            timed_out;
    logic            counting;
    logic [15:0]     n_new;
    logic            len_bad;
    logic [ADDR_W:0] word_inc;
    logic            word_last;

    assign xfer       = byte_valid_i && byte_ready_o;
    assign load_start = start_i && (state_q == S_RUN || state_q == S_ERR);
    assign timed_out  = !xfer && (timer_q == TMO_LAST);
    assign n_new      = {byte_i, len_lo_q};
    // Reject empty images and images that would not fit in memory
    assign len_bad    = (n_new == 16'd0) ||
                        (32'(n_new) > (32'd1 << ADDR_W));
    // Index is ADDR_W+1 wide so a full-memory image ends without wrapping
    assign word_inc   = word_idx_q + IDX_ONE;
    assign word_last  = (32'(word_inc) == 32'(n_q));

    always_comb begin
        counting = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: counting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                 counting = 1'b1;
`endif
            default:                counting = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN, S_ERR: begin
                if (start_i) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (xfer)           state_d = S_LEN1;
                else if (timed_out) state_d = S_ERR;
            end
            S_LEN1: begin
                if (xfer)           state_d = len_bad ? S_ERR : S_DATA;
                else if (timed_out) state_d = S_ERR;
            end
            S_DATA: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) state_d = S_WRITE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = word_last ? S_CSUM : S_DATA;
`else
                state_d = word_last ? S_DONE : S_DATA;
`endif
            end
            S_DONE: state_d = S_RUN;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)           state_d = (byte_i == csum_q) ? S_DONE : S_ERR;
                else if (timed_out) state_d = S_ERR;
            end
`endif
            default: state_d = S_RUN;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        byte_ready_o = 1'b0;
        imem_we_o    = 1'b0;
        core_rst_o   = 1'b1;
        busy_o       = 1'b1;
        err_o        = 1'b0;
        unique case (state_q)
            S_RUN: begin
                core_rst_o = 1'b0;
                busy_o     = 1'b0;
            end
            S_ERR: begin
                busy_o = 1'b0;
                err_o  = 1'b1;
            end
            S_LEN0, S_LEN1, S_DATA: byte_ready_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                 byte_ready_o = 1'b1;
`endif
            S_WRITE: imem_we_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_lo_q   <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            timer_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else if (load_start) begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
            timer_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (xfer) begin
                timer_q <= '0;
            end else if (counting) begin
                timer_q <= timer_q + TMR_ONE;
            end

            if (xfer && state_q == S_LEN0) len_lo_q <= byte_i;
            if (xfer && state_q == S_LEN1) n_q <= n_new;

            if (xfer && state_q == S_DATA) begin
                shreg_q    <= {byte_i, shreg_q[31:8]};
                byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ byte_i;
`endif
                if (byte_idx_q == 2'd3) begin
                    wdata_q <= {byte_i, shreg_q[31:8]};
                    addr_q  <= word_idx_q[ADDR_W-1:0];
                end
            end

            if (state_q == S_WRITE) word_idx_q <= word_inc;
        end
    end

    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign words_loaded_o = word_idx_q;

endmodule
